// File: rtl/ibex_hpm_counter_bank_pkg.sv
// rtl/ibex_hpm_counter_bank_pkg.sv - limits, index-width helper and per-counter state type
package ibex_hpm_pkg;

    localparam int unsigned HpmMaxCounters = 29;
    localparam int unsigned HpmMaxWidth    = 64;
    localparam int unsigned HpmMaxEvents   = 32;

    // Width of a counter index; a single-counter bank still gets one index bit.
    function automatic int unsigned hpm_idx_width(input int unsigned num_counters);
        return (num_counters > 1) ? $clog2(num_counters) : 1;
    endfunction

    // Per-counter state, zero-extended to the architectural maxima.
    typedef struct packed {
        logic [HpmMaxWidth-1:0]  value;
        logic [HpmMaxEvents-1:0] mask;
        logic                    ovf;
    } hpm_state_t;

endpackage

// File: rtl/ibex_hpm_counter_bank_if.sv
// rtl/ibex_hpm_counter_bank_if.sv - CSR write/read bus of the counter bank
interface ibex_hpm_counter_bank_if #(
    parameter int unsigned NumEvents = 16,
    parameter int unsigned IdxW      = 2
);
    logic [IdxW-1:0]      wr_idx_i;
    logic                 cnt_we_lo_i;
    logic                 cnt_we_hi_i;
    logic                 sel_we_i;
    logic [31:0]          wdata_i;
    logic [IdxW-1:0]      rd_idx_i;
    logic [63:0]          rd_val_o;
    logic [NumEvents-1:0] rd_sel_o;

    modport master (
        output wr_idx_i, cnt_we_lo_i, cnt_we_hi_i, sel_we_i, wdata_i, rd_idx_i,
        input  rd_val_o, rd_sel_o
    );

    modport slave (
        input  wr_idx_i, cnt_we_lo_i, cnt_we_hi_i, sel_we_i, wdata_i, rd_idx_i,
        output rd_val_o, rd_sel_o
    );
endinterface

// File: rtl/ibex_hpm_counter_slice.sv
// rtl/ibex_hpm_counter_slice.sv - one counter with select mask, write mux and overflow flag
module ibex_hpm_counter_slice
    import ibex_hpm_pkg::*;
#(
    parameter int unsigned CounterWidth = 40,
    parameter int unsigned NumEvents    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumEvents-1:0] event_q_i,
    input  logic                 inhibit_i,
    input  logic                 wr_hit_i,
    input  logic                 cnt_we_lo_i,
    input  logic                 cnt_we_hi_i,
    input  logic                 sel_we_i,
    input  logic [31:0]          wdata_i,
    input  logic                 ovf_clr_i,
    output hpm_state_t           state_o
);

    localparam bit HasHigh = (CounterWidth > 32);

    logic [CounterWidth-1:0] cnt_q, cnt_d;
    logic [NumEvents-1:0]    sel_q;
    logic                    ovf_q, ovf_d;
    logic                    cnt_write, cnt_inc, cnt_wrap;
    logic [63:0]             wr_val;
    logic                    unused_wr_val;

    // A high-half write on a narrow counter is a no-op, so it must not steal the increment.
    assign cnt_write = wr_hit_i && (cnt_we_lo_i || (HasHigh && cnt_we_hi_i));
    assign cnt_inc   = (|(event_q_i & sel_q)) && !inhibit_i;
    assign cnt_wrap  = cnt_inc && !cnt_write && (&cnt_q);
    assign ovf_d     = cnt_wrap | (ovf_q & ~ovf_clr_i);

    // Merge the written halves over the current value; bits above CounterWidth fall away.
    always_comb begin
        wr_val = 64'(cnt_q);
        if (cnt_we_lo_i) wr_val[31:0]  = wdata_i;
        if (cnt_we_hi_i) wr_val[63:32] = wdata_i;
    end

    assign unused_wr_val = ^wr_val;

    // Next count: a write overrides the increment of the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_write) begin
            cnt_d = wr_val[CounterWidth-1:0];
        end else if (cnt_inc) begin
            cnt_d = cnt_q + CounterWidth'(1);
        end
    end

    // Counter, select mask and sticky overflow registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            sel_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (wr_hit_i && sel_we_i) begin
                sel_q <= wdata_i[NumEvents-1:0];
            end
        end
    end

    // Present the state zero-extended to the package maxima.
    always_comb begin
        state_o       = '0;
        state_o.value = HpmMaxWidth'(cnt_q);
        state_o.mask  = HpmMaxEvents'(sel_q);
        state_o.ovf   = ovf_q;
    end

endmodule

// File: rtl/ibex_hpm_counter_bank.sv
// rtl/ibex_hpm_counter_bank.sv - bank of hardware performance-monitor counters
module ibex_hpm_counter_bank
    import ibex_hpm_pkg::*;
#(
    parameter int unsigned NumCounters  = 4,
    parameter int unsigned CounterWidth = 40,
    parameter int unsigned NumEvents    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumEvents-1:0]   event_i,
    input  logic [NumCounters-1:0] inhibit_i,
    input  logic [NumCounters-1:0] ovf_clr_i,
    ibex_hpm_counter_bank_if.slave bus,
    output logic [NumCounters-1:0] ovf_o,
    output logic                   irq_o
);

    localparam int unsigned IdxW = hpm_idx_width(NumCounters);

    logic [NumEvents-1:0] event_q;
    hpm_state_t           state [NumCounters];
    hpm_state_t           rd_state;
    logic                 unused_rd_state;

    // Every event pulse is registered once before it reaches the counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            event_q <= '0;
        end else begin
            event_q <= event_i;
        end
    end

    for (genvar i = 0; i < NumCounters; i++) begin : g_slice
        ibex_hpm_counter_slice #(
            .CounterWidth (CounterWidth),
            .NumEvents    (NumEvents)
        ) u_slice (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .event_q_i   (event_q),
            .inhibit_i   (inhibit_i[i]),
            .wr_hit_i    (bus.wr_idx_i == IdxW'(i)),
            .cnt_we_lo_i (bus.cnt_we_lo_i),
            .cnt_we_hi_i (bus.cnt_we_hi_i),
            .sel_we_i    (bus.sel_we_i),
            .wdata_i     (bus.wdata_i),
            .ovf_clr_i   (ovf_clr_i[i]),
            .state_o     (state[i])
        );
        assign ovf_o[i] = state[i].ovf;
    end

    // Read mux; indices past the last counter read as zero.
    always_comb begin
        rd_state = '0;
        if (32'(bus.rd_idx_i) < NumCounters) begin
            rd_state = state[bus.rd_idx_i];
        end
    end

    assign bus.rd_val_o    = rd_state.value;
    assign bus.rd_sel_o    = rd_state.mask[NumEvents-1:0];
    assign unused_rd_state = ^{rd_state.mask, rd_state.ovf};
    assign irq_o           = |ovf_o;

endmodule

// File: tb/tb_ibex_hpm_counter_bank.sv
// tb/tb_ibex_hpm_counter_bank.sv - self-checking bench for ibex_hpm_counter_bank
module tb_ibex_hpm_counter_bank;
    import ibex_hpm_pkg::*;

    localparam logic [63:0] MASK40 = 64'h0000_00FF_FFFF_FFFF;

    typedef struct {
        string       name;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [15:0] a_event, b_event;
    logic [4:0]  a_inhibit, a_ovf_clr, a_ovf;
    logic [2:0]  b_inhibit, b_ovf_clr, b_ovf;
    logic        a_irq, b_irq;

    logic [63:0] m_cnt [5];
    logic [15:0] m_sel [5];
    logic [15:0] m_evq;

    ibex_hpm_counter_bank_if #(.NumEvents(16), .IdxW(3)) bus_a ();
    ibex_hpm_counter_bank_if #(.NumEvents(16), .IdxW(2)) bus_b ();

    ibex_hpm_counter_bank #(.NumCounters(5), .CounterWidth(40), .NumEvents(16)) dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .event_i(a_event), .inhibit_i(a_inhibit),
        .ovf_clr_i(a_ovf_clr), .bus(bus_a), .ovf_o(a_ovf), .irq_o(a_irq)
    );

    ibex_hpm_counter_bank #(.NumCounters(3), .CounterWidth(8), .NumEvents(16)) dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .event_i(b_event), .inhibit_i(b_inhibit),
        .ovf_clr_i(b_ovf_clr), .bus(bus_b), .ovf_o(b_ovf), .irq_o(b_irq)
    );

    always #10 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_cnt[i] = '0;
            m_sel[i] = '0;
        end
        m_evq = '0;
    endtask

    // Advances one clock edge, updating the reference model of bank A from the driven inputs.
    task automatic tick();
        for (int i = 0; i < 5; i++) begin
            logic hit;
            hit = (int'(bus_a.wr_idx_i) == i);
            if (hit && (bus_a.cnt_we_lo_i || bus_a.cnt_we_hi_i)) begin
                if (bus_a.cnt_we_lo_i) m_cnt[i][31:0]  = bus_a.wdata_i;
                if (bus_a.cnt_we_hi_i) m_cnt[i][63:32] = bus_a.wdata_i;
                m_cnt[i] = m_cnt[i] & MASK40;
            end else if (((m_evq & m_sel[i]) != 16'h0) && !a_inhibit[i]) begin
                m_cnt[i] = (m_cnt[i] + 64'd1) & MASK40;
            end
            if (hit && bus_a.sel_we_i) m_sel[i] = bus_a.wdata_i[15:0];
        end
        m_evq = a_event;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_writes();
        bus_a.cnt_we_lo_i = 0; bus_a.cnt_we_hi_i = 0; bus_a.sel_we_i = 0;
        bus_b.cnt_we_lo_i = 0; bus_b.cnt_we_hi_i = 0; bus_b.sel_we_i = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_ni = 0;
        a_event = 0; b_event = 0; a_inhibit = 0; b_inhibit = 0; a_ovf_clr = 0; b_ovf_clr = 0;
        bus_a.wr_idx_i = 0; bus_a.wdata_i = 0; bus_a.rd_idx_i = 0;
        bus_b.wr_idx_i = 0; bus_b.wdata_i = 0; bus_b.rd_idx_i = 0;
        idle_writes();
        model_reset();
        repeat (2) @(negedge clk);
        rst_ni = 1;
        @(negedge clk);
        for (int i = 0; i <= 5; i++) begin
            bus_a.rd_idx_i = 3'(i);
            sb.push_back('{$sformatf("reset_rd_val[%0d]", i), 64'h0});
            sb.push_back('{$sformatf("reset_rd_sel[%0d]", i), 64'h0});
            #1;
            e = sb.pop_front(); n_cmp++;
            if (bus_a.rd_val_o !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_a.rd_val_o, e.val); end
            e = sb.pop_front(); n_cmp++;
            if (64'(bus_a.rd_sel_o) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_a.rd_sel_o, e.val); end
        end
        sb.push_back('{"reset_ovf_a", 64'h0});
        sb.push_back('{"reset_irq_a", 64'h0});
        sb.push_back('{"reset_ovf_b", 64'h0});
        sb.push_back('{"reset_irq_b", 64'h0});
        e = sb.pop_front(); n_cmp++;
        if (64'(a_ovf) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, a_ovf, e.val); end
        e = sb.pop_front(); n_cmp++;
        if (64'(a_irq) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, a_irq, e.val); end
        e = sb.pop_front(); n_cmp++;
        if (64'(b_ovf) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, b_ovf, e.val); end
        e = sb.pop_front(); n_cmp++;
        if (64'(b_irq) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, b_irq, e.val); end
    endtask

    task automatic test_counting();
        exp_t e;
        bus_a.wr_idx_i = 3'd1; bus_a.sel_we_i = 1; bus_a.wdata_i = 32'h0003;
        tick();
        bus_a.sel_we_i = 0;
        bus_a.rd_idx_i = 3'd1;
        for (int k = 0; k < 10; k++) begin
            a_event = (k < 5) ? 16'h0003 : ((k < 8) ? 16'h0004 : 16'h0000);
            tick();
            sb.push_back('{$sformatf("count_c1_edge%0d", k + 1), m_cnt[1]});
            if (k == 0) sb.push_back('{"count_c1_before_latency", 64'd0});
            if (k == 1) sb.push_back('{"count_c1_first_inc", 64'd1});
            if (k == 9) sb.push_back('{"count_c1_final", 64'd5});
            while (sb.size() > 0) begin
                e = sb.pop_front(); n_cmp++;
                if (bus_a.rd_val_o !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_a.rd_val_o, e.val); end
            end
        end
        bus_a.rd_idx_i = 3'd0;
        sb.push_back('{"count_c0_idle", 64'd0});
        #1;
        e = sb.pop_front(); n_cmp++;
        if (bus_a.rd_val_o !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_a.rd_val_o, e.val); end
    endtask

    task automatic test_split_write();
        exp_t e;
        bus_a.wr_idx_i = 3'd2; bus_a.rd_idx_i = 3'd2;
        bus_a.cnt_we_lo_i = 1; bus_a.wdata_i = 32'hFFFF_FFFF;
        tick();
        bus_a.cnt_we_lo_i = 0; bus_a.cnt_we_hi_i = 1; bus_a.wdata_i = 32'hFFFF_FFAB;
        tick();
        bus_a.cnt_we_hi_i = 0;
        sb.push_back('{"split_write_mask40", 64'h0000_00AB_FFFF_FFFF});
        e = sb.pop_front(); n_cmp++;
        if (bus_a.rd_val_o !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_a.rd_val_o, e.val); end
        bus_a.cnt_we_lo_i = 1; bus_a.cnt_we_hi_i = 1; bus_a.wdata_i = 32'h1234_5678;
        tick();
        idle_writes();
        sb.push_back('{"split_write_both", 64'h0000_0078_1234_5678});
        e = sb.pop_front(); n_cmp++;
        if (bus_a.rd_val_o !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_a.rd_val_o, e.val); end
    endtask

    task automatic test_wrap();
        exp_t e;
        bus_b.wr_idx_i = 2'd2; bus_b.rd_idx_i = 2'd2;
        bus_b.sel_we_i = 1; bus_b.wdata_i = 32'h1;
        tick();
        bus_b.sel_we_i = 0; bus_b.cnt_we_lo_i = 1; bus_b.wdata_i = 32'hFE; b_event = 16'h1;
        tick();
        bus_b.cnt_we_lo_i = 0;
        // Per-edge expectations: value, ovf vector, irq.
        sb.push_back('{"wrap_preset", 64'hFE}); sb.push_back('{"wrap_preset_ovf", 64'h0}); sb.push_back('{"wrap_preset_irq", 64'h0});
        for (int k = 0; k < 7; k++) begin
            case (k)
                1: begin sb.push_back('{"wrap_ff", 64'hFF}); sb.push_back('{"wrap_ff_ovf", 64'h0}); sb.push_back('{"wrap_ff_irq", 64'h0}); end
                2: begin sb.push_back('{"wrap_00", 64'h00}); sb.push_back('{"wrap_00_ovf", 64'h4}); sb.push_back('{"wrap_00_irq", 64'h1}); end
                3: begin sb.push_back('{"clr_nonwrap", 64'h01}); sb.push_back('{"clr_nonwrap_ovf", 64'h0}); sb.push_back('{"clr_nonwrap_irq", 64'h0}); end
                4: begin sb.push_back('{"hi_write_ignored", 64'h02}); sb.push_back('{"hi_write_ovf", 64'h0}); sb.push_back('{"hi_write_irq", 64'h0}); end
                5: begin sb.push_back('{"preset_ff_wins", 64'hFF}); sb.push_back('{"preset_ff_ovf", 64'h0}); sb.push_back('{"preset_ff_irq", 64'h0}); end
                6: begin sb.push_back('{"clr_on_wrap", 64'h00}); sb.push_back('{"clr_on_wrap_ovf", 64'h4}); sb.push_back('{"clr_on_wrap_irq", 64'h1}); end
                default: ;
            endcase
            e = sb.pop_front(); n_cmp++;
            if (bus_b.rd_val_o !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_b.rd_val_o, e.val); end
            e = sb.pop_front(); n_cmp++;
            if (64'(b_ovf) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, b_ovf, e.val); end
            e = sb.pop_front(); n_cmp++;
            if (64'(b_irq) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, b_irq, e.val); end
            // Stimulus for the next edge.
            b_ovf_clr = 3'b000;
            bus_b.cnt_we_lo_i = 0; bus_b.cnt_we_hi_i = 0;
            case (k)
                2: b_ovf_clr = 3'b100;
                3: begin bus_b.cnt_we_hi_i = 1; bus_b.wdata_i = 32'hFFFF_FFFF; end
                4: begin bus_b.cnt_we_lo_i = 1; bus_b.wdata_i = 32'hFF; end
                5: b_ovf_clr = 3'b100;
                default: ;
            endcase
            if (k < 6) tick();
        end
        // Out-of-range write on the three-counter bank lands nowhere.
        b_ovf_clr = 0; b_event = 16'h0;
        bus_b.wr_idx_i = 2'd3; bus_b.cnt_we_lo_i = 1; bus_b.sel_we_i = 1; bus_b.wdata_i = 32'h77;
        tick();
        idle_writes();
        sb.push_back('{"b_oor_write_c2", 64'h01});
        sb.push_back('{"b_oor_write_c0", 64'h00});
        sb.push_back('{"b_oor_read_val", 64'h00});
        sb.push_back('{"b_oor_read_sel", 64'h00});
        e = sb.pop_front(); n_cmp++;
        if (bus_b.rd_val_o !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_b.rd_val_o, e.val); end
        bus_b.rd_idx_i = 2'd0; #1;
        e = sb.pop_front(); n_cmp++;
        if (bus_b.rd_val_o !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_b.rd_val_o, e.val); end
        bus_b.rd_idx_i = 2'd3; #1;
        e = sb.pop_front(); n_cmp++;
        if (bus_b.rd_val_o !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_b.rd_val_o, e.val); end
        e = sb.pop_front(); n_cmp++;
        if (64'(bus_b.rd_sel_o) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_b.rd_sel_o, e.val); end
    endtask

    task automatic test_write_vs_inc();
        exp_t e;
        a_event = 16'h0;
        bus_a.sel_we_i = 1; bus_a.wdata_i = 32'h1;
        bus_a.wr_idx_i = 3'd0; tick();
        bus_a.wr_idx_i = 3'd3; tick();
        bus_a.sel_we_i = 0;
        a_event = 16'h0001;
        repeat (3) tick();
        bus_a.wr_idx_i = 3'd0; bus_a.cnt_we_lo_i = 1; bus_a.wdata_i = 32'h10;
        tick();
        bus_a.cnt_we_lo_i = 0;
        sb.push_back('{"write_beats_inc_c0", 64'h10});
        sb.push_back('{"other_counter_inc_c3", 64'd3});
        bus_a.rd_idx_i = 3'd0; #1;
        e = sb.pop_front(); n_cmp++;
        if (bus_a.rd_val_o !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_a.rd_val_o, e.val); end
        bus_a.rd_idx_i = 3'd3; #1;
        e = sb.pop_front(); n_cmp++;
        if (bus_a.rd_val_o !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_a.rd_val_o, e.val); end
        tick();
        sb.push_back('{"resume_inc_c0", 64'h11});
        sb.push_back('{"resume_inc_c3", 64'd4});
        bus_a.rd_idx_i = 3'd0; #1;
        e = sb.pop_front(); n_cmp++;
        if (bus_a.rd_val_o !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_a.rd_val_o, e.val); end
        bus_a.rd_idx_i = 3'd3; #1;
        e = sb.pop_front(); n_cmp++;
        if (bus_a.rd_val_o !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_a.rd_val_o, e.val); end
    endtask

    task automatic test_inhibit();
        exp_t e;
        a_inhibit = 5'b00001;
        repeat (10) tick();
        sb.push_back('{"inhibit_hold_c0", 64'h11});
        sb.push_back('{"inhibit_other_c3", 64'd14});
        bus_a.rd_idx_i = 3'd0; #1;
        e = sb.pop_front(); n_cmp++;
        if (bus_a.rd_val_o !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_a.rd_val_o, e.val); end
        bus_a.rd_idx_i = 3'd3; #1;
        e = sb.pop_front(); n_cmp++;
        if (bus_a.rd_val_o !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_a.rd_val_o, e.val); end
        bus_a.wr_idx_i = 3'd0; bus_a.cnt_we_lo_i = 1; bus_a.wdata_i = 32'h55;
        tick();
        bus_a.cnt_we_lo_i = 0;
        bus_a.rd_idx_i = 3'd0;
        sb.push_back('{"inhibit_write_lands", 64'h55});
        #1;
        e = sb.pop_front(); n_cmp++;
        if (bus_a.rd_val_o !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_a.rd_val_o, e.val); end
        a_inhibit = 5'b00000;
        tick();
        sb.push_back('{"uninhibit_inc", 64'h56});
        e = sb.pop_front(); n_cmp++;
        if (bus_a.rd_val_o !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_a.rd_val_o, e.val); end
        // Quiesce events, then fire an out-of-range write at every enable.
        a_event = 16'h0;
        repeat (2) tick();
        bus_a.wr_idx_i = 3'd5; bus_a.cnt_we_lo_i = 1; bus_a.cnt_we_hi_i = 1; bus_a.sel_we_i = 1;
        bus_a.wdata_i = 32'hDEAD_BEEF;
        tick();
        idle_writes();
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{$sformatf("oor_write_val[%0d]", i), m_cnt[i]});
            sb.push_back('{$sformatf("oor_write_sel[%0d]", i), 64'(m_sel[i])});
            bus_a.rd_idx_i = 3'(i); #1;
            e = sb.pop_front(); n_cmp++;
            if (bus_a.rd_val_o !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_a.rd_val_o, e.val); end
            e = sb.pop_front(); n_cmp++;
            if (64'(bus_a.rd_sel_o) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_a.rd_sel_o, e.val); end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        a_event = 16'h0001;
        tick();
        bus_a.rd_idx_i = 3'd3;
        #2 rst_ni = 0;
        model_reset();
        sb.push_back('{"async_reset_immediate_c3", 64'h0});
        sb.push_back('{"async_reset_ovf_b", 64'h0});
        #1;
        e = sb.pop_front(); n_cmp++;
        if (bus_a.rd_val_o !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_a.rd_val_o, e.val); end
        e = sb.pop_front(); n_cmp++;
        if (64'(b_ovf) !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, b_ovf, e.val); end
        #1 rst_ni = 1;
        tick();
        sb.push_back('{"async_reset_dropped_c3", m_cnt[3]});
        e = sb.pop_front(); n_cmp++;
        if (bus_a.rd_val_o !== e.val) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, bus_a.rd_val_o, e.val); end
    endtask

    initial begin
        test_reset();
        test_counting();
        test_split_write();
        test_wrap();
        test_write_vs_inc();
        test_inhibit();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
